ol_softstart_pwm: RTL and testbench

Open-loop soft-start sequencer and PWM generator for the SMPS power stage. It drives the 8-bit duty select into `ol_duty_sel` and ramps it one code at a time from 0 toward a target. It captures the returned on-time once per switching period and produces the gate PWM from a free-running period counter. It sits between the host/config registers and the gate driver, and enforces enable and fault shutdown.

---
 rtl/ol_softstart_pwm.sv | 114 +++++++++++
 tb/tb_ol_softstart_pwm.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ol_softstart_pwm.sv
// Open-loop soft-start sequencer and PWM generator: ramps the duty select toward a target,
// latches the returned on-time once per switching period and drives the gate from it.
module ol_softstart_pwm #(
  parameter int unsigned PERIOD   = 1000,
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_fault,
  input  logic [7:0]  i_target,
  output logic [7:0]  o_sel,
  input  logic [10:0] i_ton,
  output logic        o_pwm,
  output logic        o_period_start,
  output logic        o_at_target,
  output logic [1:0]  o_state
);

  localparam int unsigned     DivW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [10:0]     CntMax = 11'(PERIOD - 1);
  localparam logic [10:0]     TonMax = 11'(PERIOD);
  localparam logic [DivW-1:0] DivMax = DivW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRamp  = 2'd1,
    StRun   = 2'd2,
    StFault = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [10:0]     cnt_q, cnt_d;
  logic [10:0]     ton_q, ton_d;
  logic [DivW-1:0] div_q, div_d;
  logic [7:0]      sel_q, sel_d;
  logic            running;
  logic            wrap;

  assign running = (state_q == StRamp) || (state_q == StRun);
  assign wrap    = running && (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    if (!i_en) begin
      state_d = StIdle;
    end else if (i_fault) begin
      state_d = StFault;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StRamp;
        StRamp:  if (sel_q == i_target) state_d = StRun;
        StRun:   if (sel_q != i_target) state_d = StRamp;
        StFault: state_d = StFault;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ton_d = ton_q;
    div_d = div_q;
    sel_d = sel_q;
    if (state_d == StIdle || state_d == StFault) begin
      cnt_d = '0;
      ton_d = '0;
      div_d = '0;
      sel_d = '0;
    end else if (running) begin
      // Leaving IDLE needs no action: every register is already zero there.
      cnt_d = wrap ? 11'd0 : cnt_q + 11'd1;
      if (wrap) begin
        // Sampled with the pre-step select, so duty lags the select by one period.
        ton_d = (i_ton > TonMax) ? TonMax : i_ton;
        if (div_q == DivMax) begin
          div_d = '0;
          if (state_q == StRamp) begin
            if (sel_q < i_target) begin
              sel_d = sel_q + 8'd1;
            end else if (sel_q > i_target) begin
              sel_d = sel_q - 8'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ton_q   <= '0;
      div_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ton_q   <= ton_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
    end
  end

  assign o_sel          = sel_q;
  assign o_pwm          = running && (cnt_q < ton_q);
  assign o_period_start = running && (cnt_q == 11'd0);
  assign o_at_target    = (state_q == StRun);
  assign o_state        = state_q;

endmodule

// File: tb/tb_ol_softstart_pwm.sv
// Directed bench for ol_softstart_pwm; the duty-select block is modelled as ton = 4 * sel,
// with an override that forces an over-range on-time.
module tb_ol_softstart_pwm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        fault;
  logic [7:0]  target;
  logic [7:0]  sel;
  logic [10:0] ton;
  logic        pwm;
  logic        period_start;
  logic        at_target;
  logic [1:0]  state;
  logic        ton_force = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ton = ton_force ? 11'd1500 : {1'b0, sel, 2'b00};

  ol_softstart_pwm #(
    .PERIOD   (1000),
    .RAMP_DIV (4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_en           (en),
    .i_fault        (fault),
    .i_target       (target),
    .o_sel          (sel),
    .i_ton          (ton),
    .o_pwm          (pwm),
    .o_period_start (period_start),
    .o_at_target    (at_target),
    .o_state        (state)
  );

  task automatic wait_sel(input logic [7:0] v, input int budget);
    int n = 0;
    while (sel !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sel !== v) begin
      errors++;
      $display("FAIL wait_sel: o_sel=%0d required %0d within %0d cycles", sel, v, budget);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b1;
    fault  = 1'b0;
    target = 8'd2;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({sel, pwm, period_start, at_target, state} !== 13'd0) begin
        errors++;
        $display("FAIL reset_outputs: sel=%0d pwm=%b ps=%b at=%b st=%0d required all 0",
                 sel, pwm, period_start, at_target, state);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: st=%0d ps=%b required st=1 ps=1", state, period_start);
    end
  endtask

  task automatic test_softstart();
    int width;
    int wexp;
    logic [7:0] sexp;
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL ss_idle: st=%0d required 0", state);
    end
    target = 8'd2;
    en     = 1'b1;
    for (int p = 0; p <= 10; p++) begin
      width = 0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (pwm === 1'b1) width++;
        if (c == 0) begin
          sexp = (p < 4) ? 8'd0 : (p < 8) ? 8'd1 : 8'd2;
          checks++;
          if (sel !== sexp || period_start !== 1'b1) begin
            errors++;
            $display("FAIL ss_period_start p=%0d: sel=%0d ps=%b required sel=%0d ps=1",
                     p, sel, period_start, sexp);
          end
        end
        if (p == 8 && c <= 1) begin
          checks++;
          if (at_target !== (c == 1)) begin
            errors++;
            $display("FAIL ss_at_target c=%0d: at=%b required %b", c, at_target, c == 1);
          end
        end
      end
      wexp = (p <= 4) ? 0 : (p <= 8) ? 4 : 8;
      checks++;
      if (width != wexp) begin
        errors++;
        $display("FAIL ss_width p=%0d: width=%0d required %0d", p, width, wexp);
      end
    end
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL ss_run: st=%0d required 2", state);
    end
  endtask

  task automatic test_fault_mid_ramp();
    target = 8'd10;
    wait_sel(8'd5, 20000);
    repeat (5) @(negedge clk);
    checks++;
    if (pwm !== 1'b1) begin
      errors++;
      $display("FAIL fault_pre_pulse: pwm=%b required 1", pwm);
    end
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    checks++;
    if (pwm !== 1'b0 || state !== 2'd3 || sel !== 8'd0) begin
      errors++;
      $display("FAIL fault_entry: pwm=%b st=%0d sel=%0d required pwm=0 st=3 sel=0",
               pwm, state, sel);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (state !== 2'd3 || pwm !== 1'b0) begin
      errors++;
      $display("FAIL fault_latched: st=%0d pwm=%b required st=3 pwm=0", state, pwm);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL fault_clear: st=%0d required 0", state);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || sel !== 8'd0 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL fault_restart: st=%0d sel=%0d ps=%b required st=1 sel=0 ps=1",
               state, sel, period_start);
    end
  endtask

  task automatic test_ramp_down();
    int cm;
    int k;
    int wexp;
    logic [7:0] sexp;
    wait_sel(8'd10, 45000);
    @(negedge clk);
    checks++;
    if (state !== 2'd2 || at_target !== 1'b1) begin
      errors++;
      $display("FAIL rd_run10: st=%0d at=%b required st=2 at=1", state, at_target);
    end
    target = 8'd8;
    cm = 1;
    k  = 0;
    while (!(k == 9 && cm == 999)) begin
      @(negedge clk);
      cm++;
      if (cm == 1000) begin
        cm = 0;
        k++;
      end
      wexp = (k == 0) ? 36 : (k <= 4) ? 40 : (k <= 8) ? 36 : 32;
      checks++;
      if (pwm !== (cm < wexp)) begin
        errors++;
        $display("FAIL rd_pwm k=%0d cnt=%0d: pwm=%b required %b", k, cm, pwm, cm < wexp);
      end
      if (cm == 0) begin
        sexp = (k < 4) ? 8'd10 : (k < 8) ? 8'd9 : 8'd8;
        checks++;
        if (sel !== sexp || period_start !== 1'b1) begin
          errors++;
          $display("FAIL rd_sel k=%0d: sel=%0d ps=%b required sel=%0d ps=1",
                   k, sel, period_start, sexp);
        end
      end
      if ((k == 0 && cm == 2) || (k == 8 && cm == 1)) begin
        checks++;
        if (state !== ((k == 0) ? 2'd1 : 2'd2)) begin
          errors++;
          $display("FAIL rd_state k=%0d: st=%0d required %0d", k, state, (k == 0) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_extremes();
    int highs = 0;
    int lows = 0;
    int n = 0;
    en     = 1'b0;
    target = 8'd0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL ext_ramp: st=%0d required 1", state);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd2 || at_target !== 1'b1) begin
      errors++;
      $display("FAIL ext_run: st=%0d at=%b required st=2 at=1", state, at_target);
    end
    repeat (2000) begin
      @(negedge clk);
      if (pwm !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL ext_zero_duty: high clocks=%0d required 0", highs);
    end
    ton_force = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 1100);
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL ext_wait_period: no period start within %0d cycles", n);
    end
    for (int i = 0; i <= 1000; i++) begin
      if (i > 0) @(negedge clk);
      if (pwm !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || period_start !== 1'b1) begin
      errors++;
      $display("FAIL ext_full_duty: low clocks=%0d ps=%b required 0 low and ps=1", lows, period_start);
    end
    ton_force = 1'b0;
  endtask

  task automatic test_simultaneous();
    int highs = 0;
    en    = 1'b0;
    fault = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL sim_idle: st=%0d required 0", state);
    end
    en    = 1'b1;
    fault = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd3 || pwm !== 1'b0) begin
      errors++;
      $display("FAIL sim_fault: st=%0d pwm=%b required st=3 pwm=0", state, pwm);
    end
    repeat (10) begin
      @(negedge clk);
      if (pwm !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL sim_no_pulse: high clocks=%0d required 0", highs);
    end
    en    = 1'b0;
    fault = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL sim_release: st=%0d required 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_softstart();
    test_fault_mid_ramp();
    test_ramp_down();
    test_extremes();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
